// File: rtl/nibble_recomposer.sv
// Rebuilds an operand word from per-nibble alphabet codes (alphabet[SEL] << SL, weighted 16^i, LSN first).
// Latency: out_valid rises the cycle after the last nibble code of a word is accepted.
// Backpressure: while a word is held (out_ready=0) in_ready stays low and no codes are consumed.
module nibble_recomposer #(
    parameter int LOG2_WIDTH        = 3,
    parameter int WIDTH             = 2**LOG2_WIDTH,
    parameter int LOG2_NIBBLE_WIDTH = 2,
    parameter int NIBBLE_WIDTH      = 2**LOG2_NIBBLE_WIDTH,
    parameter int NUM_NIBBLES       = WIDTH/NIBBLE_WIDTH,
    parameter int CNT_W             = (LOG2_WIDTH-LOG2_NIBBLE_WIDTH > 0) ? LOG2_WIDTH-LOG2_NIBBLE_WIDTH : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LOG2_NIBBLE_WIDTH-1:0] in_sel,
    input  logic [LOG2_NIBBLE_WIDTH-1:0] in_sl,
    input  logic                         in_zero,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH+1:0]             out_data,
    output logic                         out_ovf
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH+1:0] acc_q, acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [WIDTH+1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    logic [5:0]       nib_val;
    logic             nib_big;
    logic [WIDTH+1:0] contrib;
    logic             accept;
    logic             last_nib;

    // Handshake flags are pure decodes of the registered state.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // Nibble value and its weighted contribution at the current nibble position.
    always_comb begin
        nib_val  = in_zero ? 6'd0 : (6'({in_sel, 1'b1}) << in_sl);
        nib_big  = (nib_val > 6'd15);
        contrib  = (WIDTH+2)'(nib_val) << (NIBBLE_WIDTH * count_q);
        accept   = in_valid & in_ready;
        last_nib = (count_q == CNT_W'(NUM_NIBBLES-1));
    end

    // Next-state logic: accumulate nibbles, publish the word, then wait for the output handshake.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        ovf_acc_d  = ovf_acc_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (last_nib) begin
                        out_data_d = acc_q + contrib;
                        out_ovf_d  = ovf_acc_q | nib_big;
                        acc_d      = '0;
                        ovf_acc_d  = 1'b0;
                        count_d    = '0;
                        state_d    = ST_HOLD;
                    end else begin
                        acc_d      = acc_q + contrib;
                        ovf_acc_d  = ovf_acc_q | nib_big;
                        count_d    = count_q + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // State registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACCUM;
            count_q    <= '0;
            acc_q      <= '0;
            ovf_acc_q  <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            ovf_acc_q  <= ovf_acc_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_nibble_recomposer.sv
// Testbench for nibble_recomposer: directed test-plan steps plus random traffic vs a word-level model.
// Inputs driven and outputs sampled on the falling clock edge.
// Backpressure exercised both directed and randomly via out_ready.
module tb_nibble_recomposer;

    localparam int WIDTH = 8;
    localparam int NUM   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_sel = 2'd0;
    logic [1:0]       in_sl = 2'd0;
    logic             in_zero = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH+1:0] out_data;
    logic             out_ovf;

    int tests = 0;
    int fails = 0;

    // Reference model state: nibble values collected so far, and the word awaiting handshake.
    int   pend[$];
    bit   exp_hold = 1'b0;
    int   exp_word = 0;
    bit   exp_ovf  = 1'b0;

    nibble_recomposer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_sl     (in_sl),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic step(input logic vld, input logic [1:0] sel, input logic [1:0] sl,
                        input logic z, input logic ordy);
        int nv;
        int w;
        bit o;
        in_valid  = vld;
        in_sel    = sel;
        in_sl     = sl;
        in_zero   = z;
        out_ready = ordy;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !exp_hold});
        if (exp_hold) begin
            if (ordy) exp_hold = 1'b0;
        end else if (vld) begin
            nv = z ? 0 : ((2 * int'(sel) + 1) << sl);
            pend.push_back(nv);
            if (pend.size() == NUM) begin
                w = 0;
                o = 1'b0;
                foreach (pend[i]) begin
                    w += pend[i] * (16 ** i);
                    if (pend[i] > 15) o = 1'b1;
                end
                exp_word = w;
                exp_ovf  = o;
                exp_hold = 1'b1;
                pend.delete();
            end
        end
        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_hold});
        if (exp_hold) begin
            chk("out_data", 32'(out_data), exp_word);
            chk("out_ovf", {31'd0, out_ovf}, {31'd0, exp_ovf});
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pend.delete();
        exp_hold = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    endtask

    initial begin
        int pulses;
        int mask;
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Exact word: 6 then 3 -> 0x036
        step(1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
        step(1'b1, 2'b01, 2'b00, 1'b0, 1'b1);
        chk("exact_data", 32'(out_data), 32'h036);
        chk("exact_ovf", {31'd0, out_ovf}, 32'd0);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);

        // Zero nibble ignores SEL/SL -> 0x050
        step(1'b1, 2'b11, 2'b11, 1'b1, 1'b1);
        step(1'b1, 2'b10, 2'b00, 1'b0, 1'b1);
        chk("zero_data", 32'(out_data), 32'h050);
        chk("zero_ovf", {31'd0, out_ovf}, 32'd0);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);

        // Overflowing approximated code, maximum range -> 0x388
        step(1'b1, 2'b00, 2'b11, 1'b0, 1'b1);
        step(1'b1, 2'b11, 2'b11, 1'b0, 1'b1);
        chk("ovf_data", 32'(out_data), 32'h388);
        chk("ovf_flag", {31'd0, out_ovf}, 32'd1);
        chk("ovf_top", {30'd0, out_data[9:8]}, 32'd3);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);

        // Backpressure: word 0x036 held while a code waits on the input
        step(1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
        step(1'b1, 2'b01, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00, 2'b10, 1'b0, 1'b0);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_data", 32'(out_data), 32'h036);
        end
        step(1'b1, 2'b00, 2'b10, 1'b0, 1'b1);
        chk("bp_released", {31'd0, out_valid}, 32'd0);
        step(1'b1, 2'b00, 2'b10, 1'b0, 1'b1);
        step(1'b1, 2'b00, 2'b00, 1'b0, 1'b1);
        chk("bp_next_word", 32'(out_data), 32'h014);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);

        // Reset mid-word discards the partial nibble
        step(1'b1, 2'b01, 2'b01, 1'b0, 1'b1);
        do_reset();
        step(1'b1, 2'b00, 2'b00, 1'b0, 1'b1);
        step(1'b1, 2'b01, 2'b00, 1'b0, 1'b1);
        chk("midrst_data", 32'(out_data), 32'h031);
        chk("midrst_ovf", {31'd0, out_ovf}, 32'd0);
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1);

        // Back-to-back streaming: 4 words in 12 cycles
        pulses = 0;
        mask   = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) == 0), 1'b1);
            if (out_valid === 1'b1) begin
                pulses++;
                mask |= (1 << i);
            end
        end
        chk("stream_pulses", pulses, 32'd4);
        chk("stream_mask", mask, 32'h492);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
